// File: rtl/sprite_spawn.sv
// -----------------------------------------------------------------------------
// sprite_spawn
//   Motion generator for one sprite object. A trigger sweeps the sprite's
//   offset pair in a straight line from (HSRC,VSRC) to (HDST,VDST) over STEP
//   ticks. The design then returns to idle. The module is clocked once per
//   video frame.
//
//   Ports
//     clk      in   1       rising-edge frame tick
//     rst_n    in   1       asynchronous active-low reset
//     en       in   1       trigger, sampled only while idle
//     hoffset  out  HWIDTH  current horizontal offset (signed, registered)
//     voffset  out  VWIDTH  current vertical offset (signed, registered)
//     active   out  1       high while a sweep is running (registered)
//
//   Each position is SRC + floor((DST-SRC)*k/STEP) for k = 0..STEP. All
//   outputs are registered from the next-state values, so there is no
//   combinational path from en to an output.
// -----------------------------------------------------------------------------
module sprite_spawn #(
  parameter int                       HWIDTH = 12,
  parameter int                       VWIDTH = 12,
  parameter logic signed [HWIDTH-1:0] HSRC   = {HWIDTH{1'b0}},
  parameter logic signed [VWIDTH-1:0] VSRC   = {VWIDTH{1'b0}},
  parameter logic signed [HWIDTH-1:0] HDST   = {HWIDTH{1'b0}},
  parameter logic signed [VWIDTH-1:0] VDST   = {VWIDTH{1'b0}},
  parameter int                       STEP   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  output logic signed [HWIDTH-1:0] hoffset,
  output logic signed [VWIDTH-1:0] voffset,
  output logic                     active
);

  // The guard keeps the counter at least one bit wide. This lets an illegal
  // STEP reach the error below instead of failing on a zero-width vector.
  localparam int KW  = (STEP >= 1) ? $clog2(STEP + 1) : 1;
  localparam int HMW = HWIDTH + KW + 2;
  localparam int VMW = VWIDTH + KW + 2;

  localparam logic [KW-1:0]         K_LAST_C  = KW'(STEP);
  localparam logic [KW-1:0]         K_ONE_C   = KW'(1'b1);
  localparam logic signed [HMW-1:0] H_DELTA_C = HMW'(HDST) - HMW'(HSRC);
  localparam logic signed [VMW-1:0] V_DELTA_C = VMW'(VDST) - VMW'(VSRC);
  localparam logic signed [HMW-1:0] H_STEP_C  = HMW'(STEP);
  localparam logic signed [VMW-1:0] V_STEP_C  = VMW'(STEP);

  if (STEP < 1) begin : g_bad_step
    $error("sprite_spawn: STEP must be >= 1");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                     state_r, state_nxt_s;
  logic [KW-1:0]              k_r, k_nxt_s;
  logic signed [HWIDTH-1:0]   hoffset_r;
  logic signed [VWIDTH-1:0]   voffset_r;
  logic                       active_r;

  logic signed [HMW-1:0]      h_kext_s, h_num_s, h_quo_s, h_rem_s, h_flr_s;
  logic signed [VMW-1:0]      v_kext_s, v_num_s, v_quo_s, v_rem_s, v_flr_s;
  logic signed [HWIDTH-1:0]   h_pos_s;
  logic signed [VWIDTH-1:0]   v_pos_s;

  // Next-state and step-counter logic
  always_comb begin
    state_nxt_s = state_r;
    k_nxt_s     = k_r;
    case (state_r)
      ST_IDLE: begin
        k_nxt_s = {KW{1'b0}};
        if (en) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        // The completion edge always goes idle. It ignores en, so a new
        // sweep can start only after at least one idle frame.
        if (k_r == K_LAST_C) begin
          state_nxt_s = ST_IDLE;
          k_nxt_s     = {KW{1'b0}};
        end else begin
          state_nxt_s = ST_RUN;
          k_nxt_s     = k_r + K_ONE_C;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        k_nxt_s     = {KW{1'b0}};
      end
    endcase
  end

  // Horizontal position for the next step.
  // Truncating division is corrected by one when the result is negative and
  // inexact, which gives floor.
  always_comb begin
    h_kext_s = HMW'(k_nxt_s);
    h_num_s  = H_DELTA_C * h_kext_s;
    h_quo_s  = h_num_s / H_STEP_C;
    h_rem_s  = h_num_s % H_STEP_C;
    if (h_num_s[HMW-1] && (|h_rem_s)) begin
      h_flr_s = h_quo_s - {{(HMW-1){1'b0}}, 1'b1};
    end else begin
      h_flr_s = h_quo_s;
    end
    h_pos_s = HSRC + h_flr_s[HWIDTH-1:0];
  end

  // Vertical position for the next step, with the same floor correction
  always_comb begin
    v_kext_s = VMW'(k_nxt_s);
    v_num_s  = V_DELTA_C * v_kext_s;
    v_quo_s  = v_num_s / V_STEP_C;
    v_rem_s  = v_num_s % V_STEP_C;
    if (v_num_s[VMW-1] && (|v_rem_s)) begin
      v_flr_s = v_quo_s - {{(VMW-1){1'b0}}, 1'b1};
    end else begin
      v_flr_s = v_quo_s;
    end
    v_pos_s = VSRC + v_flr_s[VWIDTH-1:0];
  end

  // State, counter and registered outputs. Reset snaps back to the source point.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      k_r       <= {KW{1'b0}};
      hoffset_r <= HSRC;
      voffset_r <= VSRC;
      active_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      k_r       <= k_nxt_s;
      hoffset_r <= h_pos_s;
      voffset_r <= v_pos_s;
      active_r  <= (state_nxt_s == ST_RUN);
    end
  end

  assign hoffset = hoffset_r;
  assign voffset = voffset_r;
  assign active  = active_r;

endmodule

// File: tb/tb_sprite_spawn.sv
// -----------------------------------------------------------------------------
// tb_sprite_spawn
//   Scoreboard bench for sprite_spawn. A behavioural model runs in step with
//   each driven clock. At every active edge the model pushes the expected
//   {active, hoffset, voffset} onto a queue. On the following falling edge the
//   entry is popped and compared with the DUT.
//
//   The model computes positions with real-valued floor.
//
//   A second instance covers the STEP=1 case.
// -----------------------------------------------------------------------------
module tb_sprite_spawn;

  localparam int STEP_C = 32;
  localparam int HSRC_C = -80;
  localparam int VSRC_C = -140;
  localparam int HDST_C = -120;
  localparam int VDST_C = 220;

  typedef struct packed {
    logic        act;
    logic [11:0] h;
    logic [11:0] v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        en1;
  logic [11:0] h_w, v_w, h1_w, v1_w;
  logic        act_w, act1_w;

  exp_t        sb_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  logic        m_run;
  int          m_k;

  always #5 clk = ~clk;

  sprite_spawn #(
    .HWIDTH(12), .VWIDTH(12),
    .HSRC(-12'sd80), .VSRC(-12'sd140),
    .HDST(-12'sd120), .VDST(12'sd220),
    .STEP(32)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hoffset(h_w), .voffset(v_w), .active(act_w)
  );

  sprite_spawn #(
    .HWIDTH(12), .VWIDTH(12),
    .HSRC(12'sd0), .VSRC(12'sd0),
    .HDST(12'sd100), .VDST(12'sd100),
    .STEP(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1),
    .hoffset(h1_w), .voffset(v1_w), .active(act1_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] s12(input int x);
    logic [11:0] t;
    t = x[11:0];
    return {20'd0, t};
  endfunction

  function automatic logic [11:0] mpos(input int src, input int dst, input int k);
    real q;
    int  t;
    q = $floor(real'((dst - src) * k) / real'(STEP_C));
    t = src + $rtoi(q);
    return t[11:0];
  endfunction

  // One frame: drive en, advance the model at the edge, compare at the falling edge.
  task automatic tick(input logic e);
    exp_t ex;
    en = e;
    @(posedge clk);
    if (!m_run) begin
      m_k = 0;
      if (e) m_run = 1'b1;
    end else if (m_k == STEP_C) begin
      m_run = 1'b0;
      m_k   = 0;
    end else begin
      m_k = m_k + 1;
    end
    ex.act = m_run;
    ex.h   = mpos(HSRC_C, HDST_C, m_k);
    ex.v   = mpos(VSRC_C, VDST_C, m_k);
    sb_q.push_back(ex);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
    end else begin
      ex = sb_q.pop_front();
      check("sb_active", {31'd0, act_w}, {31'd0, ex.act});
      check("sb_h", {20'd0, h_w}, {20'd0, ex.h});
      check("sb_v", {20'd0, v_w}, {20'd0, ex.v});
    end
  endtask

  initial begin
    int cnt;
    rst_n = 1'b0;
    en    = 1'b0;
    en1   = 1'b0;
    m_run = 1'b0;
    m_k   = 0;

    // 1: reset values, then five idle frames
    #12;
    check("rst_active", {31'd0, act_w}, 32'd0);
    check("rst_h", {20'd0, h_w}, s12(HSRC_C));
    check("rst_v", {20'd0, v_w}, s12(VSRC_C));
    check("rst1_h", {20'd0, h1_w}, s12(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick(1'b0);
    check("idle_h", {20'd0, h_w}, 32'h0000_0FB0);
    check("idle_v", {20'd0, v_w}, 32'h0000_0F74);

    // 2: reference points of a single sweep
    tick(1'b1);
    check("trig_active", {31'd0, act_w}, 32'd1);
    tick(1'b0);
    check("k1_h", {20'd0, h_w}, s12(-82));
    check("k1_v", {20'd0, v_w}, s12(-129));
    for (int i = 0; i < 15; i++) tick(1'b0);
    check("k16_h", {20'd0, h_w}, s12(-100));
    check("k16_v", {20'd0, v_w}, s12(40));
    for (int i = 0; i < 16; i++) tick(1'b0);
    check("k32_h", {20'd0, h_w}, s12(-120));
    check("k32_v", {20'd0, v_w}, s12(220));
    check("k32_active", {31'd0, act_w}, 32'd1);
    tick(1'b0);
    check("done_active", {31'd0, act_w}, 32'd0);
    tick(1'b0);

    // 3: count the active frames of one trigger
    tick(1'b1);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (!act_w) break;
      cnt++;
      tick(1'b0);
    end
    check("active_len", cnt, 32'd33);
    check("after_h", {20'd0, h_w}, s12(HSRC_C));
    check("after_v", {20'd0, v_w}, s12(VSRC_C));

    // 4: en held high, then random en pulses, including mid-sweep
    cnt = 0;
    for (int i = 0; i < 68; i++) begin
      tick(1'b1);
      if (act_w) cnt++;
    end
    check("held_high_cnt", cnt, 32'd66);
    for (int i = 0; i < 60; i++) tick(1'($urandom_range(0, 1)));
    while (m_run) tick(1'b0);
    tick(1'b0);

    // 5: asynchronous reset in the middle of a sweep
    tick(1'b1);
    for (int i = 0; i < 10; i++) tick(1'b0);
    check("pre_rst_h", {20'd0, h_w}, {20'd0, mpos(HSRC_C, HDST_C, 10)});
    #2 rst_n = 1'b0;
    #1;
    check("async_active", {31'd0, act_w}, 32'd0);
    check("async_h", {20'd0, h_w}, s12(HSRC_C));
    check("async_v", {20'd0, v_w}, s12(VSRC_C));
    m_run = 1'b0;
    m_k   = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0);

    // 6: STEP=1 instance goes 0 -> 100 in two active frames
    en1 = 1'b1;
    tick(1'b0);
    en1 = 1'b0;
    check("s1_k0_active", {31'd0, act1_w}, 32'd1);
    check("s1_k0_h", {20'd0, h1_w}, s12(0));
    tick(1'b0);
    check("s1_k1_active", {31'd0, act1_w}, 32'd1);
    check("s1_k1_h", {20'd0, h1_w}, s12(100));
    check("s1_k1_v", {20'd0, v1_w}, s12(100));
    tick(1'b0);
    check("s1_idle_active", {31'd0, act1_w}, 32'd0);
    check("s1_idle_h", {20'd0, h1_w}, s12(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
